serial_adder: RTL and testbench

- Parametrised, multi-cycle successor to the single-bit full adder (FA).
- Adds or subtracts two WIDTH-bit operands, processing DIGIT bits per clock through a DIGIT-bit ripple chain of full-adder cells.
- The carry is registered between digits.
- Used where area matters more than latency; it has a start/busy/done handshake toward the controlling FSM.

---
 rtl/serial_adder.sv | 101 ++++++++++
 tb/tb_serial_adder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Digit-serial add/subtract: DIGIT bits per clock through a ripple of full-adder cells, carry registered between digits.
// Latency: start accepted on edge 0, digits on edges 1..STEPS, done pulses in the cycle after edge STEPS.
// Backpressure: none; start is ignored while busy, and a held start restarts on the edge that ends the done cycle.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             rout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("serial_adder: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] sum;
    logic [DIGIT:0]   c;
    logic [WIDTH-1:0] acc_next;

    // One digit of full-adder cells; c[DIGIT-1] is the carry into the digit MSB.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = carry;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = op_a[i] ^ op_b[i] ^ c[i];
            c[i+1]   = (op_a[i] & op_b[i]) | (c[i] & (op_a[i] ^ op_b[i]));
        end
        acc_next = (acc >> DIGIT) | (WIDTH'(sum) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            z     <= '0;
            rout  <= 1'b0;
            ovf   <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is A + ~B + ~borrow, so the run loop only ever adds.
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? ~rin : rin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> DIGIT;
                    op_b  <= op_b >> DIGIT;
                    acc   <= acc_next;
                    carry <= c[DIGIT];
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(STEPS - 1)) begin
                        z     <= acc_next;
                        rout  <= c[DIGIT];
                        ovf   <= c[DIGIT-1] ^ c[DIGIT];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and exhaustive checks of serial_adder in 8x1 and 4x2 configurations.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start8, rin8, sub8, busy8, done8, rout8, ovf8;
    logic [7:0] a8, b8, z8;
    logic       start4, rin4, sub4, busy4, done4, rout4, ovf4;
    logic [3:0] a4, b4, z4;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .rin(rin8), .sub(sub8),
        .busy(busy8), .done(done8), .z(z8), .rout(rout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(4), .DIGIT(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .rin(rin4), .sub(sub4),
        .busy(busy4), .done(done4), .z(z4), .rout(rout4), .ovf(ovf4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Signed/unsigned integer arithmetic reference, independent of carry-chain structure.
    function automatic void model(input int w, input int a, input int b, input int rin, input int sub,
                                  output int ez, output int er, output int eo);
        int half, mask, sa, sb, s, sv;
        half = 1 << (w - 1);
        mask = (1 << w) - 1;
        sa   = (a >= half) ? a - 2 * half : a;
        sb   = (b >= half) ? b - 2 * half : b;
        if (sub == 0) begin
            s  = a + b + rin;
            er = (s > mask) ? 1 : 0;
            sv = sa + sb + rin;
        end else begin
            s  = a - b - rin;
            er = (a >= b + rin) ? 1 : 0;
            sv = sa - sb - rin;
        end
        ez = s & mask;
        eo = (sv >= half || sv < -half) ? 1 : 0;
    endfunction

    function automatic logic [7:0] hs_a(input int k);
        return 8'(k * 37 + 11);
    endfunction
    function automatic logic [7:0] hs_b(input int k);
        return 8'(k * 53 + 200);
    endfunction
    function automatic logic hs_rin(input int k);
        return 1'((k / 3) % 2);
    endfunction
    function automatic logic hs_sub(input int k);
        return 1'(k % 2);
    endfunction

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic rin,
                        input logic sub, input logic [7:0] ez, input logic er, input logic eo);
        int n, nb;
        a8 = a; b8 = b; rin8 = rin; sub8 = sub; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = ~b; rin8 = ~rin; sub8 = ~sub;
        n  = 0;
        nb = busy8;
        while (!done8 && n < 40) begin
            tick();
            n++;
            nb += busy8;
        end
        check({tag, "_lat"}, n, 8);
        check({tag, "_busy"}, nb, 8);
        check({tag, "_z"}, z8, ez);
        check({tag, "_rout"}, rout8, er);
        check({tag, "_ovf"}, ovf8, eo);
        tick();
        check({tag, "_pulse"}, done8, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, seen, ez, er, eo, last_z;

        rst_n = 1'b0;
        start8 = 0; a8 = 0; b8 = 0; rin8 = 0; sub8 = 0;
        start4 = 0; a4 = 0; b4 = 0; rin4 = 0; sub4 = 0;
        #3;
        check("rst8_outs", {busy8, done8, z8, rout8, ovf8}, 0);
        check("rst4_outs", {busy4, done4, z4, rout4, ovf4}, 0);
        #9 rst_n = 1'b1;
        tick();

        run8("add",   8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0);
        run8("carry", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        run8("ovf",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run8("sub1",  8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        run8("sub2",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        run8("sub3",  8'h10, 8'h03, 1'b1, 1'b1, 8'h0C, 1'b1, 1'b0);
        last_z = 8'h0C;

        // start held high: accepts on edges 0, 9, 18 with operands changing every cycle
        a8 = hs_a(0); b8 = hs_b(0); rin8 = hs_rin(0); sub8 = hs_sub(0); start8 = 1'b1;
        for (int j = 0; j < 27; j++) begin
            tick();
            if (j % 9 == 8) begin
                model(8, int'(hs_a(j - 8)), int'(hs_b(j - 8)), int'(hs_rin(j - 8)), int'(hs_sub(j - 8)), ez, er, eo);
                check("hs_done", done8, 1);
                check("hs_z", z8, ez);
                check("hs_rout", rout8, er);
                check("hs_ovf", ovf8, eo);
                last_z = ez;
            end else begin
                check("hs_idle_done", done8, 0);
                check("hs_busy", busy8, 1);
                check("hs_hold_z", z8, last_z);
            end
            if (j == 26) start8 = 1'b0;
            else begin
                a8 = hs_a(j + 1); b8 = hs_b(j + 1); rin8 = hs_rin(j + 1); sub8 = hs_sub(j + 1);
            end
        end

        // start pulsed mid-run must not disturb the operation in flight or queue another
        a8 = 8'h12; b8 = 8'h34; rin8 = 0; sub8 = 0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 40) begin
            tick();
            n++;
            if (n == 3) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; rin8 = 1; sub8 = 1; end
            if (n == 4) start8 = 1'b0;
        end
        check("pulse_lat", n, 8);
        check("pulse_z", z8, 8'h46);
        check("pulse_rout", rout8, 0);
        check("pulse_ovf", ovf8, 0);
        tick();
        check("pulse_noqueue", busy8, 0);

        run8("pre_rst", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // asynchronous reset after edge 3 of a run
        a8 = 8'h3C; b8 = 8'h0F; rin8 = 0; sub8 = 0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy8, 0);
        check("arst_done", done8, 0);
        check("arst_z", z8, 0);
        check("arst_rout", rout8, 0);
        check("arst_ovf", ovf8, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) seen++;
        end
        check("arst_no_done", seen, 0);
        run8("post_rst", 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0);

        // 4-bit, 2-bit digits: every {a,b,rin} for both modes, back to back
        for (int s = 0; s < 2; s++) begin
            for (int v = 0; v < 512; v++) begin
                a4 = 4'((v >> 5) & 15); b4 = 4'((v >> 1) & 15); rin4 = 1'(v & 1); sub4 = 1'(s);
                start4 = 1'b1;
                tick();
                start4 = 1'b0;
                n = 0;
                while (!done4 && n < 10) begin
                    tick();
                    n++;
                end
                model(4, (v >> 5) & 15, (v >> 1) & 15, v & 1, s, ez, er, eo);
                check("x4_lat", n, 2);
                check("x4_sum", {rout4, z4}, (er << 4) | ez);
                check("x4_ovf", ovf4, eo);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
